data_mem_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 33 +++
 rtl/load_align.sv | 34 +++
 rtl/data_mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: access-size codes,
// controller state encoding, and the store-side lane helpers.
package mem_pkg;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte enables for an access; the reserved size code behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] mask, input logic [1:0] lo);
    case (mask)
      MASK_BYTE: byte_en = 4'b0001 << lo;
      MASK_HALF: byte_en = 4'b0011 << {lo[1], 1'b0};
      default:   byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] lane_wdata(input logic [1:0] mask, input logic [31:0] wd);
    case (mask)
      MASK_BYTE: lane_wdata = {4{wd[7:0]}};
      MASK_HALF: lane_wdata = {2{wd[15:0]}};
      default:   lane_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half out of the bus word and
// zero- or sign-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mask,
  input  logic        sign_ext,
  output logic [31:0] data_out
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select followed by extension; unaligned half offsets fall back to addr_lo[1].
  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (mask)
      MASK_BYTE: data_out = {{24{sign_ext & lane_b[7]}}, lane_b};
      MASK_HALF: data_out = {{16{sign_ext & lane_h[15]}}, lane_h};
      default:   data_out = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller between the EX/MEM stage and a req/ack bus.
// Optional build macro: MISALIGN_TRAP_EN -- trap misaligned half/word accesses
// instead of silently aligning them down.
//
//   state | meaning
//   IDLE  | waiting for mem_read/mem_write; latches the access
//   BUSY  | bus_req asserted, waiting for bus_ack or timeout
//   DONE  | load_valid (and maybe fault) pulse; pipeline released
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_data_mask,
  input  logic        mem_read_sign_extend,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Counter only has to reach BUS_TIMEOUT-1; the last BUSY cycle is the compare.
  localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lo_q, lo_d;
  logic [1:0]         mask_q, mask_d;
  logic               sext_q, sext_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [3:0]         bus_be_q, bus_be_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               load_valid_q, load_valid_d;
  logic               fault_q, fault_d;

  logic               req;
  logic               misalign;
  logic               timeout;
  logic [31:0]        aligned;

  assign req     = mem_read | mem_write;
  assign timeout = (state_q == BUSY) && !bus_ack && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

`ifdef MISALIGN_TRAP_EN
  // Misaligned half/word accesses are trapped before reaching the bus.
  always_comb begin
    misalign = ((mem_data_mask == MASK_HALF) && addr[0]) ||
               (mem_data_mask[1] && (addr[1:0] != 2'b00));
  end
`else
  // Low address bits are simply dropped by the lane logic.
  always_comb begin
    misalign = 1'b0;
  end
`endif

  load_align u_load_align (
    .rdata    (bus_rdata),
    .addr_lo  (lo_q),
    .mask     (mask_q),
    .sign_ext (sext_q),
    .data_out (aligned)
  );

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lo_q         <= '0;
      mask_q       <= '0;
      sext_q       <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      mask_q       <= mask_d;
      sext_q       <= sext_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state logic; an ack coinciding with timeout counts as completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = misalign ? DONE : BUSY;
      BUSY:    if (bus_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pipeline stall: asserted combinationally as soon as a request is seen.
  always_comb begin
    stall = ((state_q == IDLE) && req) || (state_q == BUSY);
  end

  // Datapath next values: access capture, timeout counter, completion results.
  always_comb begin
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    mask_d       = mask_q;
    sext_d       = sext_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    bus_req_d    = (state_d == BUSY);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          lo_d   = addr[1:0];
          mask_d = mem_data_mask;
          sext_d = mem_read_sign_extend;
          if (misalign) begin
            load_valid_d = 1'b1;
            fault_d      = 1'b1;
            load_data_d  = '0;
          end else begin
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = byte_en(mem_data_mask, addr[1:0]);
            bus_wdata_d = lane_wdata(mem_data_mask, write_data);
          end
        end
      end
      BUSY: begin
        if (bus_ack) begin
          load_valid_d = 1'b1;
          if (!bus_we_q) load_data_d = aligned;
        end else if (timeout) begin
          load_valid_d = 1'b1;
          fault_d      = 1'b1;
          load_data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign fault      = fault_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (BUS_TIMEOUT = 4). Expected completion
// results are queued when a request is driven and popped on load_valid.
module tb_data_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read, mem_write, mem_read_sign_extend;
  logic [1:0]  mem_data_mask;
  logic [31:0] addr, write_data;
  logic        stall, load_valid, fault, bus_req, bus_we, bus_ack;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_ld;

  always #5 clk = ~clk;

  data_mem_ctrl #(.BUS_TIMEOUT(TO)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_data_mask        (mem_data_mask),
    .mem_read_sign_extend (mem_read_sign_extend),
    .addr                 (addr),
    .write_data           (write_data),
    .stall                (stall),
    .load_data            (load_data),
    .load_valid           (load_valid),
    .fault                (fault),
    .bus_req              (bus_req),
    .bus_we               (bus_we),
    .bus_addr             (bus_addr),
    .bus_wdata            (bus_wdata),
    .bus_be               (bus_be),
    .bus_ack              (bus_ack),
    .bus_rdata            (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [1:0] mask, input logic [31:0] a);
    if (mask == 2'b00)      m_be = (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                                   (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
    else if (mask == 2'b01) m_be = a[1] ? 4'b1100 : 4'b0011;
    else                    m_be = 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] mask, input logic [31:0] wd);
    if (mask == 2'b00)      m_wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    else if (mask == 2'b01) m_wdata = {wd[15:0], wd[15:0]};
    else                    m_wdata = wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] mask, input logic sx,
                                         input logic [31:0] a, input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * a[1:0]);
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    if (mask == 2'b00)      m_load = (sx && b[7])  ? {24'hFFFFFF, b} : {24'h0, b};
    else if (mask == 2'b01) m_load = (sx && h[15]) ? {16'hFFFF, h}   : {16'h0, h};
    else                    m_load = w;
  endfunction

  // Scoreboard: every load_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && load_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(load_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("load_data", load_data, mon_e.data);
        check("fault", 32'(fault), 32'(mon_e.fault));
      end
    end
  end

  // One access; ack_dly is the BUSY cycle index carrying bus_ack (<0: never).
  task automatic run_txn(input logic wr, input logic rd_too, input logic [1:0] mask,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rword, input int ack_dly);
    exp_t e;
    logic mis, timed_out;
    int   n;
`ifdef MISALIGN_TRAP_EN
    mis = ((mask == 2'b01) && a[0]) || (mask[1] && (a[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    timed_out = (ack_dly < 0) || (ack_dly >= TO);
    if (mis || timed_out) begin
      e.data = 32'h0; e.fault = 1'b1;
    end else if (wr) begin
      e.data = model_ld; e.fault = 1'b0;
    end else begin
      e.data = m_load(mask, sx, a, rword); e.fault = 1'b0;
    end
    model_ld = e.data;
    sb.push_back(e);

    mem_read             = !wr || rd_too;
    mem_write            = wr;
    mem_data_mask        = mask;
    mem_read_sign_extend = sx;
    addr                 = a;
    write_data           = wd;
    #1;
    check("stall_req", 32'(stall), 32'd1);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (mis) begin
      check("trap_no_req", 32'(bus_req), 32'd0);
      check("trap_valid", 32'(load_valid), 32'd1);
    end else begin
      check("bus_req", 32'(bus_req), 32'd1);
      check("stall_busy", 32'(stall), 32'd1);
      check("bus_addr", bus_addr, {a[31:2], 2'b00});
      check("bus_be", 32'(bus_be), 32'(m_be(mask, a)));
      check("bus_wdata", bus_wdata, m_wdata(mask, wd));
      check("bus_we", 32'(bus_we), 32'(wr));
      n = 0;
      while (bus_req && n < 300) begin
        if (n == ack_dly) begin
          bus_ack   = 1'b1;
          bus_rdata = rword;
        end
        @(posedge clk); #1;
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        n++;
      end
      check("bus_cycles", 32'(n), timed_out ? 32'(TO) : 32'(ack_dly + 1));
      check("valid_latency", 32'(load_valid), 32'd1);
      check("stall_done", 32'(stall), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; mem_read = 0; mem_write = 0; mem_data_mask = 0;
    mem_read_sign_extend = 0; addr = 0; write_data = 0; bus_ack = 0; bus_rdata = 0;
    model_ld = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_load_data", load_data, 32'h0);
    check("rst_valid", 32'(load_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    //       wr rd  mask   sx  addr          wd            rdata         ack
    run_txn(0, 0, 2'b10, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0);
    run_txn(0, 0, 2'b00, 1, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 0);
    run_txn(0, 0, 2'b00, 0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 0);
    run_txn(1, 0, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        0);
    run_txn(0, 0, 2'b10, 0, 32'h0000_0400, 32'h0,        32'h0,        -1);
    run_txn(0, 0, 2'b10, 0, 32'h0000_0101, 32'h0,        32'hCAFE_F00D, 0);
    run_txn(0, 0, 2'b01, 1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 2);
    run_txn(1, 1, 2'b00, 0, 32'h0000_0001, 32'h0000_0055, 32'h0,        1);
    run_txn(0, 0, 2'b11, 0, 32'h0000_010C, 32'h0,        32'h1234_5678, TO - 1);
    run_txn(1, 0, 2'b01, 0, 32'h0000_0206, 32'hFFFF_0000, 32'h0,        -1);
    run_txn(0, 0, 2'b01, 0, 32'h0000_0306, 32'h0,        32'hA5A5_1234, 0);

    // Reset in the middle of BUSY abandons the access.
    mem_read = 1'b1; mem_data_mask = 2'b10; addr = 32'h0000_0300;
    @(posedge clk); #1;
    mem_read = 1'b0;
    check("abort_req_up", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_req_drop", 32'(bus_req), 32'd0);
    check("abort_no_valid", 32'(load_valid), 32'd0);
    check("abort_load_data", load_data, 32'h0);
    rstn = 1'b1;
    model_ld = 32'h0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(load_valid), 32'd0);
    run_txn(0, 0, 2'b10, 0, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 1);

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
